// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared constants and request-entry layout for the frame-RAM arbiter
//
// Purpose: default configuration of the arbiter, the packed request-entry
// layout {wr, address, data} pushed into each channel FIFO, and a helper
// that sizes that entry for any address/data width.
// Ports: none (package).
package memory_arbiter_pkg;

  localparam int DEF_ADDRESS_WIDTH  = 25;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_PERIPHERALS    = 3;
  localparam int DEF_REQ_FIFO_DEPTH = 8;
  localparam int DEF_WEIGHT_WIDTH   = 4;
  localparam int DEF_RAM_LATENCY    = 2;

  localparam int REQ_FIFO_AW   = $clog2(DEF_REQ_FIFO_DEPTH);
  localparam int PERIPHERAL_AW = $clog2(DEF_PERIPHERALS);

  // Entry layout for the default widths; the top uses entry_width() so that
  // other widths keep the same {wr, address, data} ordering.
  typedef struct packed {
    logic                         wr;
    logic [DEF_ADDRESS_WIDTH-1:0] address;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } req_entry_t;

  function automatic int entry_width(input int aw, input int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/arbiter_req_fifo.sv
// rtl/arbiter_req_fifo.sv - single-channel synchronous request FIFO
//
// Purpose: holds one peripheral's pending requests. All DEPTH entries are
// usable; a push offered while full is dropped even if a pop happens in the
// same cycle, because full_o comes from the registered count.
// Ports:
//   clk_i, reset_n_i  clock, synchronous active-low reset
//   push_i, data_i    write side (push ignored when full)
//   pop_i, data_o     read side, data_o shows the head entry (pop ignored when empty)
//   full_o, empty_o   status from the registered count
module arbiter_req_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the wrap to 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/memory_arbiter_wrr.sv
// rtl/memory_arbiter_wrr.sv - weighted round-robin arbiter for the shared LED frame RAM
//
// Purpose: per-channel request FIFOs feed a weighted round-robin scheduler
// that issues at most one request per cycle to a synchronous RAM; read data
// is routed back to the requesting channel RAM_LATENCY+1 cycles after issue.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   req_valid/req_ready           per-channel push handshake
//   req_wr/req_address/req_data   packed per-channel request fields
//   weight                        packed per-channel burst weight (0 acts as 1)
//   mem_en/mem_wr/mem_address/mem_wdata  registered RAM command
//   mem_rdata                     RAM read data, RAM_LATENCY cycles after issue
//   rsp_data/rsp_valid            read response, rsp_valid one-hot by channel
module memory_arbiter_wrr
  import memory_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int PERIPHERALS    = DEF_PERIPHERALS,
  parameter int REQ_FIFO_DEPTH = DEF_REQ_FIFO_DEPTH,
  parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
  parameter int RAM_LATENCY    = DEF_RAM_LATENCY
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [PERIPHERALS-1:0]              req_valid,
  output logic [PERIPHERALS-1:0]              req_ready,
  input  logic [PERIPHERALS-1:0]              req_wr,
  input  logic [ADDRESS_WIDTH*PERIPHERALS-1:0] req_address,
  input  logic [DATA_WIDTH*PERIPHERALS-1:0]   req_data,
  input  logic [WEIGHT_WIDTH*PERIPHERALS-1:0] weight,
  output logic                                mem_en,
  output logic                                mem_wr,
  output logic [ADDRESS_WIDTH-1:0]            mem_address,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [PERIPHERALS-1:0]              rsp_valid
);

  localparam int CH_AW   = (PERIPHERALS > 1) ? $clog2(PERIPHERALS) : 1;
  localparam int ENTRY_W = entry_width(ADDRESS_WIDTH, DATA_WIDTH);

  logic [ENTRY_W-1:0]      fifo_din  [PERIPHERALS];
  logic [ENTRY_W-1:0]      fifo_dout [PERIPHERALS];
  logic [WEIGHT_WIDTH-1:0] eff_w     [PERIPHERALS];
  logic [PERIPHERALS-1:0]  fifo_full, fifo_empty, fifo_push, fifo_pop;

  for (genvar k = 0; k < PERIPHERALS; k++) begin : g_ch
    assign fifo_din[k] = {req_wr[k],
                          req_address[k*ADDRESS_WIDTH +: ADDRESS_WIDTH],
                          req_data[k*DATA_WIDTH +: DATA_WIDTH]};
    assign fifo_push[k] = req_valid[k] & ~fifo_full[k];
    assign eff_w[k] = (weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH] == '0)
                      ? WEIGHT_WIDTH'(1) : weight[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];

    arbiter_req_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (REQ_FIFO_DEPTH)
    ) u_fifo (
      .clk_i     (clk),
      .reset_n_i (reset_n),
      .push_i    (fifo_push[k]),
      .data_i    (fifo_din[k]),
      .pop_i     (fifo_pop[k]),
      .data_o    (fifo_dout[k]),
      .full_o    (fifo_full[k]),
      .empty_o   (fifo_empty[k])
    );
  end

  assign req_ready = ~fifo_full;

  // Scheduler state. cur_w_q is the weight latched when the current grant
  // started, so weight changes only bite at the next grant switch. burst_q==0
  // only occurs straight out of reset, where the live weight is used instead.
  logic [CH_AW-1:0]        grant_q, grant_d, sel;
  logic [WEIGHT_WIDTH-1:0] burst_q, burst_d;
  logic [WEIGHT_WIDTH-1:0] cur_w_q, cur_w_d, cur_w;
  logic                    pop_any, found;
  logic [ENTRY_W-1:0]      sel_entry;
  int                      cand_idx;

  always_comb begin
    sel      = grant_q;
    pop_any  = 1'b0;
    found    = 1'b0;
    cand_idx = 0;
    grant_d  = grant_q;
    burst_d  = burst_q;
    cur_w_d  = cur_w_q;
    cur_w    = (burst_q == '0) ? eff_w[grant_q] : cur_w_q;
    if (!fifo_empty[grant_q] && (burst_q < cur_w)) begin
      pop_any = 1'b1;
      burst_d = burst_q + WEIGHT_WIDTH'(1);
      cur_w_d = cur_w;
    end else begin
      // Search starts at grant+1 and ends on grant itself, so a lone busy
      // channel re-wins with a fresh burst.
      for (int i = 1; i <= PERIPHERALS; i++) begin
        cand_idx = (int'(grant_q) + i) % PERIPHERALS;
        if (!found && !fifo_empty[cand_idx]) begin
          found = 1'b1;
          sel   = CH_AW'(cand_idx);
        end
      end
      if (found) begin
        pop_any = 1'b1;
        grant_d = sel;
        burst_d = WEIGHT_WIDTH'(1);
        cur_w_d = eff_w[sel];
      end
    end
    fifo_pop      = '0;
    fifo_pop[sel] = pop_any;
    sel_entry     = fifo_dout[sel];
  end

  // Command register plus read-owner pipeline. rd_sel_q is aligned with
  // mem_en; rd_pipe_q[RAM_LATENCY-1] is aligned with valid mem_rdata, which
  // is registered into rsp_data together with rsp_valid.
  logic                     mem_en_q, mem_wr_q;
  logic [ADDRESS_WIDTH-1:0] mem_address_q;
  logic [DATA_WIDTH-1:0]    mem_wdata_q;
  logic [PERIPHERALS-1:0]   rd_sel_q;
  logic [PERIPHERALS-1:0]   rd_pipe_q [RAM_LATENCY];
  logic [PERIPHERALS-1:0]   rsp_valid_q;
  logic [DATA_WIDTH-1:0]    rsp_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      grant_q       <= '0;
      burst_q       <= '0;
      cur_w_q       <= '0;
      mem_en_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rd_sel_q      <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) rd_pipe_q[i] <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      burst_q  <= burst_d;
      cur_w_q  <= cur_w_d;
      mem_en_q <= pop_any;
      mem_wr_q <= pop_any & sel_entry[ENTRY_W-1];
      if (pop_any) begin
        mem_address_q <= sel_entry[DATA_WIDTH +: ADDRESS_WIDTH];
        mem_wdata_q   <= sel_entry[DATA_WIDTH-1:0];
      end
      rd_sel_q     <= (pop_any && !sel_entry[ENTRY_W-1]) ? fifo_pop : '0;
      rd_pipe_q[0] <= rd_sel_q;
      for (int i = 1; i < RAM_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
      rsp_valid_q  <= rd_pipe_q[RAM_LATENCY-1];
      rsp_data_q   <= mem_rdata;
    end
  end

  assign mem_en      = mem_en_q;
  assign mem_wr      = mem_wr_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: doc/memory_arbiter_wrr.md
Name: memory_arbiter_wrr

Overview:
- Next-generation multi-peripheral memory arbiter for the LED matrix controller's shared frame RAM.
- Each peripheral pushes read/write requests into its own request FIFO through a valid/ready handshake.
- A weighted round-robin scheduler issues at most one request per cycle to an external synchronous RAM port.
- Read data returns to the originating peripheral after a fixed, parameterised RAM latency; data width, depth, channel count and weights are all configurable.

Parameters:
- ADDRESS_WIDTH, 25: RAM word address width.
- DATA_WIDTH, 8: data word width.
- PERIPHERALS, 3: number of requesting channels (>=2).
- REQ_FIFO_DEPTH, 8: entries per channel FIFO (power of 2, >=2).
- WEIGHT_WIDTH, 4: width of each per-channel weight.
- RAM_LATENCY, 2: cycles from issue on mem_* to valid mem_rdata (>=1).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset_n  in  1  reset; synchronous, active-low.
- req_valid  in  PERIPHERALS  per-channel request valid.
- req_ready  out  PERIPHERALS  per-channel FIFO can accept.
- req_wr  in  PERIPHERALS  1 = write, 0 = read.
- req_address  in  ADDRESS_WIDTH*PERIPHERALS  packed; channel k occupies slice k.
- req_data  in  DATA_WIDTH*PERIPHERALS  packed write data.
- weight  in  WEIGHT_WIDTH*PERIPHERALS  quasi-static burst weight per channel; 0 treated as 1.
- mem_en  out  1  request issued this cycle.
- mem_wr  out  1  write enable, qualified by mem_en.
- mem_address  out  ADDRESS_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, RAM_LATENCY cycles after issue.
- rsp_data  out  DATA_WIDTH  read data, shared by all channels.
- rsp_valid  out  PERIPHERALS  one-hot; marks the channel owning rsp_data.

Behaviour:
- Reset (reset_n low at posedge): all FIFO counts and pointers 0, req_ready all 1 after reset, mem_en/mem_wr 0, mem_address/mem_wdata 0, rsp_valid 0, rsp_data 0, grant = channel 0, burst counter 0.
- Reset mid-operation discards in-flight reads: no rsp_valid is emitted for them.
- FIFO push: occurs when req_valid[k] & req_ready[k]; stores {wr, address, data}.
- req_ready[k] = (count[k] != REQ_FIFO_DEPTH), derived from registered count. Full-capacity use: all REQ_FIFO_DEPTH entries are usable.
- Full FIFO: a push offered while full is not accepted, even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged.
- Pointers wrap from REQ_FIFO_DEPTH-1 to 0.
- Scheduler, evaluated each cycle:
  - If the current grant channel is non-empty and burst < eff_weight (weight, or 1 when weight is 0): pop from it, burst+1.
  - Otherwise select the first non-empty channel in circular order starting at grant+1; this may wrap back to the current grant channel. Set grant to it, pop, burst = 1.
  - If all channels are empty: no pop, mem_en=0, grant and burst held.
- Issue is registered: the popped entry drives mem_en=1, mem_wr, mem_address and mem_wdata on the cycle after the pop. Arbitration-to-RAM latency is 1 cycle; throughput is 1 request per cycle.
- Read tracking: a RAM_LATENCY-stage shift register carries the one-hot channel select for each issued read (0 for writes and idle cycles).
- Read response: rsp_valid = final shift-register stage; rsp_data = mem_rdata registered into the same cycle, so the response appears RAM_LATENCY+1 cycles after issue.
- Writes produce no response.
- Ordering: requests within a channel issue and respond in FIFO order. No cross-channel ordering guarantee.
- Weight changes take effect at the next grant switch.

Decomposition:
- memory_arbiter_pkg holds:
  - request-entry struct/width constants (wr + address + data);
  - the localparams REQ_FIFO_AW=$clog2(REQ_FIFO_DEPTH) and PERIPHERAL_AW=$clog2(PERIPHERALS).
- One sub-module: arbiter_req_fifo, a single-channel synchronous FIFO with count, full/empty and registered pointers, instantiated PERIPHERALS times via generate.
- The scheduler and response pipeline stay in the top level.

Test Plan:
- Single read: after reset, ch1 pushes a read to addr 0x10 while the RAM model holds 0xA5 there → mem_en=1 with mem_address=0x10 one cycle after acceptance; rsp_valid=3'b010 with rsp_data=0xA5 exactly RAM_LATENCY+1 cycles after issue.
- Weighted round robin: weights {ch0=3, ch1=1, ch2=2}, all FIFOs preloaded with 6 reads → issue order 0,0,0,1,2,2,0,0,0,1,2,2,…; no idle cycles until the FIFOs are empty.
- FIFO full and wrap: ch0 pushes 8 requests with the scheduler starved (ch0 weight test via a stalled model) → req_ready[0]=0 after the 8th; the 9th is held. Drain then refill 8 more → pointers wrap and data order is preserved.
- Simultaneous events: while ch2 is full and being popped, assert req_valid[2] → not accepted that cycle, accepted the next. On a non-full FIFO, push+pop in the same cycle → count constant.
- Write then read: ch0 writes 0x3C to addr 5, then ch1 reads addr 5 → rsp_valid=3'b010, rsp_data=0x3C; no rsp_valid for the write.
- Mid-operation reset: issue 2 reads, assert reset_n=0 for one cycle before the data returns → no rsp_valid afterwards; req_ready all 1; mem_en=0.
